// File: rtl/fixed_float_pkg.sv
// fixed_float_pkg: IEEE754 format constants shared by the fixed<->float converters.
package fixed_float_pkg;
    function automatic int float_wid(bit dbl);
        return dbl ? 64 : 32;
    endfunction
    function automatic int sign_bit(bit dbl);
        return float_wid(dbl) - 1;
    endfunction
    function automatic int exp_wid(bit dbl);
        return dbl ? 11 : 8;
    endfunction
    function automatic int mant_wid(bit dbl);
        return dbl ? 52 : 23;
    endfunction
    function automatic int exp_bias(bit dbl);
        return dbl ? 1023 : 127;
    endfunction
endpackage

// File: rtl/fixed_to_float_1_lead_one_det.sv
// lead_one_det: combinational priority encoder giving the index of the highest set bit.
module lead_one_det #(
    parameter int W = 32,
    localparam int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  v,
    output logic [PW-1:0] pos,
    output logic          none
);
    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) pos = v[i] ? PW'(i) : pos;
    end
    assign none = ~|v;
endmodule

// File: rtl/fixed_to_float_1.sv
// fixed_to_float_1: 4-stage signed fixed-point to IEEE754 converter with round-to-nearest-even.
module fixed_to_float_1
    import fixed_float_pkg::*;
#(
    parameter string FLOAT_FMT = "float",
    parameter int    INT_WID   = 16,
    parameter int    FRA_WID   = 16,
    localparam int   FLOAT_WID = float_wid(FLOAT_FMT == "double")
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 in_valid,
    input  logic [INT_WID-1:0]   fixed_integer,
    input  logic [FRA_WID-1:0]   fixed_fraction,
    output logic                 out_valid,
    output logic [FLOAT_WID-1:0] float_val,
    output logic                 zero,
    output logic                 inexact
);
    localparam bit DBL  = FLOAT_FMT == "double";
    localparam int W    = INT_WID + FRA_WID;
    localparam int EW   = exp_wid(DBL);
    localparam int MW   = mant_wid(DBL);
    localparam int BIAS = exp_bias(DBL);
    localparam int PW   = $clog2(W);

    if (!(FLOAT_FMT == "float" || DBL) || INT_WID < 2 || INT_WID > 64 ||
        FRA_WID < 1 || FRA_WID > 64 || W > 96) begin : g_bad_param
        $error("fixed_to_float_1: unsupported parameter set");
    end

    logic [W-1:0]   v, mag_s1, mag_s2;
    logic [W-2:0]   norm_s3;
    logic [PW-1:0]  p, p_s2;
    logic [EW:0]    exp_s3;
    logic [3:0]     vld;
    logic           none, sign_s1, sign_s2, sign_s3, zero_s2, zero_s3;
    logic [W+MW:0]  ext;
    logic [MW:0]    rnd;
    logic           guard, sticky, inc;

    assign v = {fixed_integer, fixed_fraction};
    assign out_valid = vld[3];

    lead_one_det #(.W(W)) u_lod (.v(mag_s1), .pos(p), .none(none));

    // Bits below the leading one, zero-padded so guard/sticky vanish when nothing is discarded
    always_comb begin
        ext    = {norm_s3, {(MW + 2){1'b0}}};
        guard  = ext[W];
        sticky = |ext[W-1:0];
        inc    = guard & (sticky | ext[W+1]);
        rnd    = {1'b0, ext[W+MW -: MW]} + (MW + 1)'(inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld       <= '0;
            sign_s1   <= 1'b0;
            mag_s1    <= '0;
            sign_s2   <= 1'b0;
            mag_s2    <= '0;
            p_s2      <= '0;
            zero_s2   <= 1'b0;
            sign_s3   <= 1'b0;
            zero_s3   <= 1'b0;
            norm_s3   <= '0;
            exp_s3    <= '0;
            float_val <= '0;
            zero      <= 1'b0;
            inexact   <= 1'b0;
        end else if (clk_en) begin
            vld       <= {vld[2:0], in_valid};
            sign_s1   <= v[W-1];
            mag_s1    <= v[W-1] ? -v : v;
            sign_s2   <= sign_s1;
            mag_s2    <= mag_s1;
            p_s2      <= p;
            zero_s2   <= none;
            sign_s3   <= sign_s2 & ~zero_s2;
            zero_s3   <= zero_s2;
            norm_s3   <= (W - 1)'(mag_s2 << (PW'(W - 1) - p_s2));
            exp_s3    <= zero_s2 ? '0 : (EW + 1)'(int'(p_s2) - FRA_WID + BIAS);
            float_val <= zero_s3 ? '0 : {sign_s3, EW'(exp_s3 + (EW + 1)'(rnd[MW])), rnd[MW-1:0]};
            zero      <= zero_s3;
            inexact   <= ~zero_s3 & (guard | sticky);
        end
    end
endmodule

// File: tb/tb_fixed_to_float_1.sv
// tb_fixed_to_float_1: scoreboard bench comparing the converter against a real-arithmetic reference.
module tb_fixed_to_float_1;
    logic        clk = 0, rst = 1, clk_en = 0, in_valid = 0;
    logic [15:0] fixed_integer = 0, fixed_fraction = 0;
    logic        out_valid, zero, inexact;
    logic [31:0] float_val;

    typedef struct { logic [31:0] f; logic z; logic x; int cap; } exp_t;
    exp_t        q[$];
    int          checks = 0, errors = 0, en_cnt = 0;
    logic [34:0] prev = '0;

    logic [15:0] di[9] = '{16'h0001, 16'hFFFE, 16'h0000, 16'h0000, 16'h8000, 16'h0100, 16'h0100, 16'h7FFF, 16'hFFFF};
    logic [15:0] df[9] = '{16'h0000, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0003, 16'hFFFF, 16'h0000};
    logic [31:0] dv[9] = '{32'h3F800000, 32'hBFC00000, 32'h00000000, 32'h37800000, 32'hC7000000,
                           32'h43800000, 32'h43800002, 32'h47000000, 32'hBF800000};
    logic        dz[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic        dx[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    logic        pat[6] = '{1, 0, 1, 1, 0, 1};

    always #5 clk = ~clk;

    fixed_to_float_1 #(.FLOAT_FMT("float"), .INT_WID(16), .FRA_WID(16)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid),
        .fixed_integer(fixed_integer), .fixed_fraction(fixed_fraction),
        .out_valid(out_valid), .float_val(float_val), .zero(zero), .inexact(inexact)
    );

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    // Exact value as a double, then rounded to single precision by hand
    function automatic exp_t model(logic [15:0] i, logic [15:0] fr);
        exp_t        r;
        real         val;
        logic [63:0] b;
        logic [28:0] rem;
        logic [23:0] m;
        int          e;
        r = '{f: 0, z: 0, x: 0, cap: 0};
        val = real'($signed({i, fr})) / 65536.0;
        if (val == 0.0) begin
            r.z = 1;
            return r;
        end
        b   = $realtobits(val);
        rem = b[28:0];
        e   = int'(b[62:52]) - 1023;
        m   = {1'b0, b[51:29]} + 24'(rem[28] && ((rem[27:0] != 0) || b[29]));
        if (m[23]) e++;
        r.f = {b[63], 8'(e + 127), m[22:0]};
        r.x = rem != 0;
        return r;
    endfunction

    task automatic drive(logic [15:0] i, logic [15:0] fr, logic v, logic ce, exp_t e);
        @(negedge clk);
        clk_en = ce;
        in_valid = v;
        fixed_integer = i;
        fixed_fraction = fr;
        if (v && ce) begin
            e.cap = en_cnt + 1;
            q.push_back(e);
        end
    endtask

    task automatic rnd_drive(logic v, logic ce);
        logic [15:0] i, fr;
        int          r;
        r  = $urandom_range(3);
        i  = r == 0 ? 16'($urandom_range(2)) : r == 1 ? 16'hFFFF : 16'($urandom);
        fr = 16'($urandom);
        drive(i, fr, v, ce, model(i, fr));
    endtask

    task automatic drain();
        @(negedge clk);
        clk_en = 1;
        in_valid = 0;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        chk("drain_left", 64'(q.size()), 0);
    endtask

    task automatic chk_zero_out(string n);
        chk({n, "_valid"}, out_valid, 0);
        chk({n, "_float"}, float_val, 0);
        chk({n, "_zero"}, zero, 0);
        chk({n, "_inexact"}, inexact, 0);
    endtask

    always @(posedge clk) begin
        logic        ce;
        logic [34:0] cur;
        exp_t        e;
        ce = clk_en;
        if (ce && !rst) en_cnt++;
        #1;
        cur = {out_valid, float_val, zero, inexact};
        if (!rst) begin
            if (!ce) chk("hold", cur, prev);
            else if (out_valid) begin
                if (q.size() == 0) chk("extra_out", out_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("float_val", float_val, e.f);
                    chk("zero", zero, e.z);
                    chk("inexact", inexact, e.x);
                    chk("latency", 64'(en_cnt - e.cap), 3);
                end
            end
        end
        prev = cur;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero_out("reset");
        rst = 0;
        for (int k = 0; k < 9; k++) drive(di[k], df[k], 1, 1, '{f: dv[k], z: dz[k], x: dx[k], cap: 0});
        drain();
        for (int k = 0; k < 6; k++) begin
            logic [15:0] i, fr;
            i  = 16'($urandom);
            fr = 16'($urandom);
            drive(i, fr, 1, pat[k], model(i, fr));
            if (!pat[k]) drive(i, fr, 1, 1, model(i, fr));
        end
        drain();
        repeat (400) rnd_drive($urandom_range(3) != 0, $urandom_range(4) != 0);
        drain();
        repeat (5) rnd_drive(1, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk_zero_out("midflight_rst");
        q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        clk_en = 1;
        in_valid = 0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
        end
        repeat (100) rnd_drive(1, $urandom_range(3) != 0);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
